// File: rtl/rs_frame_arbiter.sv
// rs_frame_arbiter: round-robin arbiter sharing one RS sync framer among NUM_CH encoders.
// A granted channel owns the output for exactly one codeword of PAYLOAD_LEN bytes.
module rs_frame_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int PAYLOAD_LEN = 255,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int CNT_W       = $clog2(PAYLOAD_LEN)
) (
    input  logic                core_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [NUM_CH*8-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]   s_axis_tvalid,
    input  logic [NUM_CH-1:0]   s_axis_tlast,
    output logic [NUM_CH-1:0]   s_axis_tready,
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic [CH_W-1:0]     m_axis_tuser,
    output logic                busy,
    output logic                frame_done,
    output logic [CH_W-1:0]     frame_ch,
    output logic                tlast_err
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t           state_q;
    logic [CH_W-1:0]  grant_q;
    logic [CH_W-1:0]  last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [CH_W-1:0]  fch_q;
    logic             terr_q;

    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   pick_d;
    logic              found_d;
    logic              cnt_last;
    logic              hs;
    logic              tlast_in;
    logic [7:0]        ch_data [NUM_CH];

    function automatic logic [CH_W-1:0] wrap(input int v);
        return CH_W'((v >= NUM_CH) ? v - NUM_CH : v);
    endfunction

    assign req      = s_axis_tvalid & ch_enable;
    assign found_d  = |req;
    assign cnt_last = (cnt_q == CNT_W'(PAYLOAD_LEN - 1));
    assign hs       = m_axis_tvalid & m_axis_tready;
    assign tlast_in = s_axis_tlast[grant_q];

    // Scan from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        pick_d = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[wrap(int'(last_q) + i)]) begin
                pick_d = wrap(int'(last_q) + i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = s_axis_tdata[8*i +: 8];
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        busy          = (state_q == XFER);
        if (state_q == XFER) begin
            m_axis_tdata           = ch_data[grant_q];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = cnt_last;
            m_axis_tuser           = grant_q;
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fch_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            terr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && found_d) begin
                        grant_q <= pick_d;
                        last_q  <= pick_d;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (hs) begin
                        terr_q <= (tlast_in != cnt_last);
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            fch_q   <= grant_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_done = done_q;
    assign frame_ch   = fch_q;
    assign tlast_err  = terr_q;

endmodule

// File: tb/tb_rs_frame_arbiter.sv
// tb_rs_frame_arbiter: directed checks of frame locking, round-robin order,
// tlast checking, async reset and sticky grant.
module tb_rs_frame_arbiter;

    localparam int PL = 255;

    logic        core_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  ch_enable;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [1:0]  m_tuser;
    logic        busy;
    logic        frame_done;
    logic [1:0]  frame_ch;
    logic        tlast_err;

    rs_frame_arbiter #(
        .NUM_CH      (4),
        .PAYLOAD_LEN (PL)
    ) dut (
        .core_clk      (core_clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .ch_enable     (ch_enable),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_ch      (frame_ch),
        .tlast_err     (tlast_err)
    );

    always #5 core_clk = ~core_clk;

    int errs   = 0;
    int checks = 0;

    int src_idx [4];
    int src_lim [4];
    int exp_idx [4];
    int err_ch;
    int err_at;
    int rdy_pct;

    int n_hs, n_bad, n_tl, n_tl_bad, n_done, done_ch, n_terr;
    int n_chg, n_rdy_bad, frame_hs, cur_user, gap;
    logic busy_q;
    int grants [$];
    int gaps [$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({m_tvalid, m_tlast, busy, frame_done, tlast_err,
                     s_tready, m_tdata, m_tuser, frame_ch});
    endfunction

    task automatic clr_mon();
        n_hs = 0; n_bad = 0; n_tl = 0; n_tl_bad = 0;
        n_done = 0; done_ch = -1; n_terr = 0;
        n_chg = 0; n_rdy_bad = 0; gap = 0; busy_q = 1'b0;
        grants.delete();
        gaps.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        for (int c = 0; c < 4; c++) begin
            src_idx[c] = 0;
            src_lim[c] = 0;
            exp_idx[c] = 0;
        end
        frame_hs = 0;
        clr_mon();
        @(negedge core_clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc();
        logic [3:0] rdy;
        @(negedge core_clk);
        for (int c = 0; c < 4; c++) begin
            s_tdata[c*8 +: 8] = 8'(c * 37 + src_idx[c]);
            s_tvalid[c] = (src_idx[c] < src_lim[c]);
            s_tlast[c]  = (src_idx[c] % PL == PL - 1) ||
                          (c == err_ch && src_idx[c] % PL == err_at);
        end
        m_tready = ($urandom_range(99) < rdy_pct);
        #1;
        rdy = s_tready;
        if (busy) begin
            if (s_tready != (4'(m_tready) << m_tuser)) n_rdy_bad++;
        end else if (s_tready != 4'b0) begin
            n_rdy_bad++;
        end
        if (m_tvalid && m_tready) begin
            int u;
            u = int'(m_tuser);
            n_hs++;
            if (frame_hs == 0) cur_user = u;
            else if (u != cur_user) n_chg++;
            if (m_tdata != 8'(u * 37 + exp_idx[u])) n_bad++;
            exp_idx[u]++;
            if (m_tlast) n_tl++;
            if (m_tlast != (frame_hs == PL - 1)) n_tl_bad++;
            frame_hs = (frame_hs == PL - 1) ? 0 : frame_hs + 1;
        end
        if (frame_done) begin
            n_done++;
            done_ch = int'(frame_ch);
        end
        if (tlast_err) n_terr++;
        if (busy && !busy_q) begin
            grants.push_back(int'(m_tuser));
            gaps.push_back(gap);
        end
        gap = busy ? 0 : gap + 1;
        busy_q = busy;
        @(posedge core_clk);
        for (int c = 0; c < 4; c++) begin
            if (s_tvalid[c] && rdy[c]) src_idx[c]++;
        end
    endtask

    task automatic run_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (n_done < n && k < budget) begin
            cyc();
            k++;
        end
        chk({tag, "_timeout"}, int'(n_done >= n), 1);
    endtask

    task automatic run_hs(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (n_hs < n && k < budget) begin
            cyc();
            k++;
        end
        chk({tag, "_timeout"}, int'(n_hs >= n), 1);
    endtask

    function automatic int g_at(input int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    function automatic int gap_at(input int i);
        return (i < gaps.size()) ? gaps[i] : -1;
    endfunction

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        ch_enable = 4'h0;
        s_tdata   = '0;
        s_tvalid  = '0;
        s_tlast   = '0;
        m_tready  = 1'b0;
        err_ch    = -1;
        err_at    = -1;
        rdy_pct   = 100;

        // Reset state
        #3;
        chk("reset_outs", outs(), 0);
        do_reset();
        chk("reset_idle", outs(), 0);

        // 1: single ch0 codeword
        enable    = 1'b1;
        ch_enable = 4'hF;
        src_lim[0] = 255;
        run_frames(1, 400, "t1");
        repeat (4) cyc();
        chk("t1_hs", n_hs, 255);
        chk("t1_data", n_bad, 0);
        chk("t1_tlast_cnt", n_tl, 1);
        chk("t1_tlast_pos", n_tl_bad, 0);
        chk("t1_done", n_done, 1);
        chk("t1_done_ch", done_ch, 0);
        chk("t1_terr", n_terr, 0);
        chk("t1_grants", grants.size(), 1);
        chk("t1_grant0", g_at(0), 0);
        chk("t1_ready", n_rdy_bad, 0);

        // 2: ch0 and ch2 alternate
        do_reset();
        src_lim[0] = 510;
        src_lim[2] = 510;
        run_frames(4, 1300, "t2");
        repeat (4) cyc();
        chk("t2_grants", grants.size(), 4);
        chk("t2_g0", g_at(0), 0);
        chk("t2_g1", g_at(1), 2);
        chk("t2_g2", g_at(2), 0);
        chk("t2_g3", g_at(3), 2);
        chk("t2_gap1", gap_at(1), 1);
        chk("t2_gap2", gap_at(2), 1);
        chk("t2_gap3", gap_at(3), 1);
        chk("t2_interleave", n_chg, 0);
        chk("t2_hs", n_hs, 1020);
        chk("t2_data", n_bad, 0);
        chk("t2_tlast_pos", n_tl_bad, 0);
        chk("t2_ready", n_rdy_bad, 0);

        // 3: ch1 with 50% downstream ready
        do_reset();
        rdy_pct = 50;
        src_lim[1] = 510;
        run_frames(2, 3000, "t3");
        rdy_pct = 100;
        repeat (4) cyc();
        chk("t3_hs", n_hs, 510);
        chk("t3_data", n_bad, 0);
        chk("t3_tlast_cnt", n_tl, 2);
        chk("t3_tlast_pos", n_tl_bad, 0);
        chk("t3_done", n_done, 2);
        chk("t3_done_ch", done_ch, 1);
        chk("t3_terr", n_terr, 0);
        chk("t3_ready", n_rdy_bad, 0);

        // 4: ch3 raises a stray tlast on byte 99
        do_reset();
        err_ch = 3;
        err_at = 99;
        src_lim[3] = 255;
        run_frames(1, 400, "t4");
        repeat (4) cyc();
        err_ch = -1;
        err_at = -1;
        chk("t4_terr", n_terr, 1);
        chk("t4_hs", n_hs, 255);
        chk("t4_tlast_cnt", n_tl, 1);
        chk("t4_tlast_pos", n_tl_bad, 0);
        chk("t4_done_ch", done_ch, 3);
        chk("t4_data", n_bad, 0);

        // 5: async reset mid-frame
        do_reset();
        src_lim[0] = 255;
        src_lim[1] = 255;
        run_hs(128, 300, "t5");
        #2;
        chk("t5_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_outs", outs(), 0);
        do_reset();
        src_lim[0] = 255;
        src_lim[1] = 255;
        run_frames(2, 700, "t5b");
        repeat (4) cyc();
        chk("t5_grants", grants.size(), 2);
        chk("t5_g0", g_at(0), 0);
        chk("t5_g1", g_at(1), 1);
        chk("t5_hs", n_hs, 510);
        chk("t5_data", n_bad, 0);
        chk("t5_tlast_cnt", n_tl, 2);

        // 6: masked channel, then sticky grant across enable drop
        do_reset();
        ch_enable = 4'b1011;
        src_lim[2] = 510;
        repeat (20) cyc();
        chk("t6_nogrant", grants.size(), 0);
        chk("t6_idle_hs", n_hs, 0);
        ch_enable = 4'hF;
        run_hs(10, 50, "t6");
        enable = 1'b0;
        run_frames(1, 400, "t6b");
        repeat (20) cyc();
        chk("t6_grants", grants.size(), 1);
        chk("t6_g0", g_at(0), 2);
        chk("t6_hs", n_hs, 255);
        chk("t6_done", n_done, 1);
        chk("t6_data", n_bad, 0);
        chk("t6_idle", int'(busy_q), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
